// File: rtl/uart_replay_buf_if.sv
// Byte stream and replay-control bundle for uart_replay_buf.
// The master side drives received bytes and the replay controls; the slave side is the buffer.
interface uart_replay_buf_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
);
  logic              start;
  logic              mode;
  logic              rx_vld;
  logic [DATA_W-1:0] rx_data;
  logic              txrdy;
  logic              tx_vld;
  logic [DATA_W-1:0] tx_data;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              overflow;
  logic              busy;

  modport master (
    output start, mode, rx_vld, rx_data, txrdy,
    input  tx_vld, tx_data, count, full, overflow, busy
  );

  modport slave (
    input  start, mode, rx_vld, rx_data, txrdy,
    output tx_vld, tx_data, count, full, overflow, busy
  );
endinterface

// File: rtl/uart_replay_buf.sv
// Circular byte buffer that either replays its whole contents on a start-button edge
// or, in streaming mode, forwards each stored byte as soon as the transmitter is idle.
module uart_replay_buf #(
  parameter int DATA_W        = 8,
  parameter int ADDR_W        = 10,
  parameter bit CLEAR_ON_DONE = 1'b1
) (
  input logic             clk,
  input logic             rst,
  uart_replay_buf_if.slave bus
);
  typedef enum logic [2:0] {IDLE, READ, SEND, WAIT_LO, WAIT_HI} state_t;

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic [DATA_W-1:0] mem [2**ADDR_W];

  state_t            state;
  logic [ADDR_W-1:0] hd, wp, rp;
  logic [ADDR_W:0]   count, len, sent, dec;
  logic              mode_r, overflow, tx_vld;
  logic [DATA_W-1:0] tx_data;
  logic              s1, s2, e_q;
  logic              start_edge, full, wr, done, clr;

  assign start_edge = s2 & ~e_q;
  assign full       = (count == DEPTH);
  assign wr         = bus.rx_vld & ~full;
  assign done       = (state == WAIT_HI) & bus.txrdy & (sent >= len);
  assign clr        = done & ~mode_r & CLEAR_ON_DONE;

  // Streaming consumes one entry per SEND; a cleared replay consumes its whole snapshot.
  always_comb begin
    dec = '0;
    if (state == SEND && mode_r) dec = (ADDR_W+1)'(1);
    else if (clr)                dec = len;
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= bus.rx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      hd       <= '0;
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      len      <= '0;
      sent     <= '0;
      mode_r   <= 1'b0;
      overflow <= 1'b0;
      tx_vld   <= 1'b0;
      tx_data  <= '0;
      s1       <= 1'b0;
      s2       <= 1'b0;
      e_q      <= 1'b0;
    end else begin
      s1     <= bus.start;
      s2     <= s1;
      e_q    <= s2;
      tx_vld <= 1'b0;
      if (wr) wp <= wp + ADDR_W'(1);
      count <= count + {{ADDR_W{1'b0}}, wr} - dec;
      if (clr) overflow <= 1'b0;
      if (bus.rx_vld && full) overflow <= 1'b1;

      unique case (state)
        IDLE: begin
          if (!bus.mode && start_edge && count != '0 && bus.txrdy) begin
            state  <= READ;
            rp     <= hd;
            len    <= count;
            sent   <= '0;
            mode_r <= 1'b0;
          end else if (bus.mode && count != '0 && bus.txrdy) begin
            state  <= READ;
            rp     <= hd;
            len    <= (ADDR_W+1)'(1);
            sent   <= '0;
            mode_r <= 1'b1;
          end
        end
        READ: begin
          tx_data <= mem[rp];
          tx_vld  <= 1'b1;
          state   <= SEND;
        end
        SEND: begin
          rp    <= rp + ADDR_W'(1);
          sent  <= sent + (ADDR_W+1)'(1);
          if (mode_r) hd <= hd + ADDR_W'(1);
          state <= WAIT_LO;
        end
        WAIT_LO: if (!bus.txrdy) state <= WAIT_HI;
        WAIT_HI: begin
          if (bus.txrdy) begin
            if (sent < len) state <= READ;
            else begin
              state <= IDLE;
              if (clr) hd <= hd + len[ADDR_W-1:0];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.tx_vld   = tx_vld;
  assign bus.tx_data  = tx_data;
  assign bus.count    = count;
  assign bus.full     = full;
  assign bus.overflow = overflow;
  assign bus.busy     = (state != IDLE);
endmodule

// File: tb/tb_uart_replay_buf.sv
// Directed bench: two 4-entry buffers (clearing and retaining) share stimulus and a
// 10-cycle-busy transmitter model; expected bytes go to queues popped by monitors.
module tb_uart_replay_buf;
  logic clk = 1'b0;
  logic rst0 = 1'b1, rst1 = 1'b1;
  logic start = 1'b0, mode = 1'b0, rx_vld = 1'b0, txrdy = 1'b1;
  logic [7:0] rx_data = '0;

  int checks = 0, errors = 0;
  int n_tx0 = 0;
  logic [7:0] q0[$], q1[$];

  uart_replay_buf_if #(.DATA_W(8), .ADDR_W(2)) b0 ();
  uart_replay_buf_if #(.DATA_W(8), .ADDR_W(2)) b1 ();

  assign b0.start = start;  assign b1.start = start;
  assign b0.mode = mode;    assign b1.mode = mode;
  assign b0.rx_vld = rx_vld; assign b1.rx_vld = rx_vld;
  assign b0.rx_data = rx_data; assign b1.rx_data = rx_data;
  assign b0.txrdy = txrdy;  assign b1.txrdy = txrdy;

  uart_replay_buf #(.DATA_W(8), .ADDR_W(2), .CLEAR_ON_DONE(1'b1)) u0 (.clk(clk), .rst(rst0), .bus(b0));
  uart_replay_buf #(.DATA_W(8), .ADDR_W(2), .CLEAR_ON_DONE(1'b0)) u1 (.clk(clk), .rst(rst1), .bus(b1));

  always #5 clk = ~clk;

  // Transmitter model: goes busy right after each tx_vld, idle again 10 cycles later.
  initial begin
    int bcnt;
    bcnt = 0;
    forever begin
      @(negedge clk);
      if (b0.tx_vld || b1.tx_vld) begin
        txrdy = 1'b0;
        bcnt  = 10;
      end else if (bcnt > 0) begin
        bcnt--;
        if (bcnt == 0) txrdy = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    logic [7:0] exp;
    if (b0.tx_vld) begin
      n_tx0++;
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL tx0_unexpected got %02h expected none", b0.tx_data);
      end else begin
        exp = q0.pop_front();
        if (b0.tx_data !== exp) begin
          errors++;
          $display("FAIL tx0_data got %02h expected %02h", b0.tx_data, exp);
        end
      end
    end
    if (b1.tx_vld) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL tx1_unexpected got %02h expected none", b1.tx_data);
      end else begin
        exp = q1.pop_front();
        if (b1.tx_data !== exp) begin
          errors++;
          $display("FAIL tx1_data got %02h expected %02h", b1.tx_data, exp);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic rx(input logic [7:0] d);
    @(posedge clk); #1;
    rx_vld = 1'b1; rx_data = d;
    @(posedge clk); #1;
    rx_vld = 1'b0;
  endtask

  task automatic press();
    @(posedge clk); #1 start = 1'b1;
    repeat (3) @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic reset0();
    @(posedge clk); #1 rst0 = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst0 = 1'b0;
  endtask

  // Done means both buffers idle with the transmitter idle for several cycles in a row.
  task automatic wait_done(input string name);
    int stable;
    bit ok;
    stable = 0;
    ok = 1'b0;
    repeat (4) @(posedge clk);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!b0.busy && !b1.busy && txrdy) stable++;
      else stable = 0;
      if (stable >= 3) begin ok = 1'b1; break; end
    end
    chk({name, "_timeout"}, {31'd0, ok}, 32'd1);
  endtask

  initial begin
    int lat;
    bit seen;
    repeat (3) @(posedge clk);
    #1 rst0 = 1'b0; rst1 = 1'b0;
    @(negedge clk);
    chk("rst_count0", b0.count, 0);     chk("rst_count1", b1.count, 0);
    chk("rst_busy0", b0.busy, 0);       chk("rst_busy1", b1.busy, 0);
    chk("rst_full0", b0.full, 0);       chk("rst_ovf0", b0.overflow, 0);
    chk("rst_txvld0", b0.tx_vld, 0);    chk("rst_txdata0", b0.tx_data, 0);

    // Replay of three bytes; the retaining buffer replays a second time.
    rx(8'h41); rx(8'h42); rx(8'h43);
    @(negedge clk);
    chk("load_count0", b0.count, 3); chk("load_count1", b1.count, 3);
    q0.push_back(8'h41); q0.push_back(8'h42); q0.push_back(8'h43);
    q1.push_back(8'h41); q1.push_back(8'h42); q1.push_back(8'h43);
    press();
    wait_done("replay1");
    chk("clear_count0", b0.count, 0); chk("keep_count1", b1.count, 3);
    q1.push_back(8'h41); q1.push_back(8'h42); q1.push_back(8'h43);
    press();
    wait_done("replay2");
    chk("keep2_count1", b1.count, 3); chk("empty_ignore_count0", b0.count, 0);
    chk("q1_drained", q1.size(), 0);
    @(posedge clk); #1 rst1 = 1'b1;

    // Fill to capacity, drop the fifth byte.
    reset0();
    rx(8'h10); rx(8'h11); rx(8'h12); rx(8'h13);
    @(negedge clk);
    chk("full_flag", b0.full, 1); chk("full_count", b0.count, 4); chk("full_ovf", b0.overflow, 0);
    rx(8'h14);
    @(negedge clk);
    chk("ovf_flag", b0.overflow, 1); chk("ovf_count", b0.count, 4);
    q0.push_back(8'h10); q0.push_back(8'h11); q0.push_back(8'h12); q0.push_back(8'h13);
    press();
    wait_done("replay_full");
    chk("full_done_count", b0.count, 0); chk("full_done_ovf", b0.overflow, 0);
    chk("full_done_full", b0.full, 0);

    // Move head to 3, then replay across the wrap with a byte arriving mid-replay.
    reset0();
    rx(8'h01); rx(8'h02); rx(8'h03);
    q0.push_back(8'h01); q0.push_back(8'h02); q0.push_back(8'h03);
    press();
    wait_done("pre_wrap");
    rx(8'h21); rx(8'h22);
    q0.push_back(8'h21); q0.push_back(8'h22);
    press();
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (b0.busy) begin seen = 1'b1; break; end
    end
    chk("wrap_busy_seen", {31'd0, seen}, 1);
    rx(8'h99);
    wait_done("wrap_replay");
    chk("wrap_count", b0.count, 1);
    q0.push_back(8'h99);
    press();
    wait_done("wrap_next");
    chk("wrap_next_count", b0.count, 0);

    // Streaming mode.
    reset0();
    mode = 1'b1;
    q0.push_back(8'h55);
    rx(8'h55);
    seen = 1'b0;
    lat = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (b0.tx_vld) begin seen = 1'b1; lat = k - 1; break; end
    end
    chk("stream_seen", {31'd0, seen}, 1);
    chk("stream_lat_le2", {31'd0, (lat <= 2)}, 1);
    q0.push_back(8'hAA);
    rx(8'hAA);
    wait_done("stream");
    chk("stream_count", b0.count, 0);
    chk("stream_q_drained", q0.size(), 0);
    mode = 1'b0;

    // Reset while waiting for the transmitter after byte 2.
    reset0();
    rx(8'h61); rx(8'h62); rx(8'h63);
    q0.push_back(8'h61); q0.push_back(8'h62);
    lat = n_tx0;
    press();
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (n_tx0 >= lat + 2) begin seen = 1'b1; break; end
    end
    chk("abort_second_tx", {31'd0, seen}, 1);
    repeat (3) @(posedge clk);
    #1 rst0 = 1'b1;
    @(posedge clk); #1 rst0 = 1'b0;
    @(negedge clk);
    chk("abort_count", b0.count, 0); chk("abort_busy", b0.busy, 0);
    repeat (40) @(posedge clk);
    chk("abort_no_more_tx", n_tx0, lat + 2);
    chk("q0_drained", q0.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/uart_replay_buf.md
UART_REPLAY_BUF -- requirements
Module: uart_replay_buf

Interface
REQ-001 Parameter DATA_W, default 8, byte width of stored and transmitted data.
REQ-002 Parameter ADDR_W, default 10, buffer depth = 2^ADDR_W entries.
REQ-003 Parameter CLEAR_ON_DONE, default 1; 1 = replay empties the buffer on completion, 0 = buffer retained.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  asynchronous replay request (button); rising edge triggers.
REQ-007 mode  in  1  0 = replay on start, 1 = streaming FIFO (auto-send).
REQ-008 rx_vld  in  1  one-cycle strobe, rx_data valid.
REQ-009 rx_data  in  DATA_W  received byte.
REQ-010 txrdy  in  1  transmitter idle (high) / busy (low).
REQ-011 tx_vld  out  1  one-cycle strobe, tx_data to send.
REQ-012 tx_data  out  DATA_W  byte to transmit, held until the next tx_vld.
REQ-013 count  out  ADDR_W+1  current number of stored entries.
REQ-014 full  out  1  count == 2^ADDR_W.
REQ-015 overflow  out  1  sticky, a byte was dropped.
REQ-016 busy  out  1  state != IDLE.

Function
REQ-017 Buffer shall be circular: head pointer hd, write pointer wp, both ADDR_W bits, wrapping modulo 2^ADDR_W.
REQ-018 rx_vld with full=0 shall write rx_data at wp, increment wp, and increment count, in every state and mode.
REQ-019 rx_vld with full=1 shall drop the byte, leave wp/count unchanged, and set overflow.
REQ-020 start shall pass through 2 synchroniser flops plus 1 edge flop; edge = sync2 & ~edge_flop.
REQ-021 FSM states: IDLE, READ, SEND, WAIT_LO, WAIT_HI.
REQ-022 IDLE->READ, mode=0: start edge, count>0, txrdy=1; latch snapshot len=count, set read pointer rp=hd, sent=0.
REQ-023 IDLE->READ, mode=1: count>0 and txrdy=1, no start needed; rp=hd, len=1.
REQ-024 A start edge shall be ignored when not IDLE, when count=0, when txrdy=0, or when mode=1.
REQ-025 READ: memory read at rp (1-cycle latency), registered into tx_data; ->SEND.
REQ-026 SEND: tx_vld=1 for exactly this cycle, rp+1, sent+1; ->WAIT_LO.
REQ-027 WAIT_LO: stay until txrdy=0, then ->WAIT_HI.
REQ-028 WAIT_HI: on txrdy=1 ->READ if sent<len, else ->IDLE (done).
REQ-029 mode=1: each SEND shall advance hd by 1 and decrement count; rx write in the same cycle leaves count unchanged.
REQ-030 mode=0 done: CLEAR_ON_DONE=1 -> hd=hd+len, count=count-len (+1 on a same-cycle write); CLEAR_ON_DONE=0 -> hd/count unchanged.
REQ-031 mode=0: bytes received during replay shall be stored but not sent in that replay (len fixed).
REQ-032 mode shall be sampled only in IDLE; changes during replay take effect after return to IDLE.
REQ-033 Latency: start edge detected at cycle N -> READ at N+1 -> tx_vld at N+2.
REQ-034 overflow shall clear only on rst, or on a mode=0 done with CLEAR_ON_DONE=1.
REQ-035 Read and write to the same address in one cycle shall return the old (stored) value; no such case is reachable when count>0.

Reset
REQ-036 rst shall set state=IDLE, hd=wp=rp=0, count=0, overflow=0, tx_vld=0, tx_data=0, synchroniser/edge flops=0; buffer contents undefined.
REQ-037 rst mid-replay shall abort immediately with no further tx_vld; all stored data shall be discarded.

Verification
REQ-038 mode=0: rx 0x41,0x42,0x43; start pulse; txrdy mimics 10-cycle busy -> tx_vld x3 with data 41,42,43; count 3->0 (CLEAR_ON_DONE=1).
REQ-039 CLEAR_ON_DONE=0: same stimulus, start twice -> 41,42,43 sent twice; count stays 3.
REQ-040 ADDR_W=2: rx 5 bytes 0x10..0x14 -> full=1 after 4, overflow=1, count=4; replay sends 10..13 only.
REQ-041 mode=1: rx 0x55 with txrdy=1 -> tx_vld within 2 cycles, data 0x55, count returns to 0; rx 0xAA during WAIT_LO -> sent after 0x55 is finished.
REQ-042 mode=0: replay of 2 bytes while rx 0x99 arrives mid-replay -> only 2 bytes sent, count=1 afterward, next replay sends 0x99 (wrap across hd=2^ADDR_W-1 -> 0 checked).
REQ-043 rst asserted in WAIT_HI of byte 2 -> no further tx_vld, count=0, busy=0 the cycle after rst.
